// File: rtl/data_mem_responder.sv
// Data-memory responder: MAR plus internal RAM, serving edge-triggered read/write strobes from the control unit.
// Latency: ack is high WAIT_STATES+1 cycles after the accepting edge; the minimum repeat interval is WAIT_STATES+2 cycles.
// Backpressure: none. Strobes or MAR loads that arrive while busy are dropped and raise the sticky proto_err flag.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mar_load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_oe,
  output logic              ack,
  output logic              busy,
  output logic [ADDR_W-1:0] mar_out,
  output logic              proto_err
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_ACK, WR_WAIT, WR_ACK} state_t;

  // With zero wait states, an accepted request skips the *_WAIT state and goes straight to *_ACK.
  localparam bit         NO_WAIT  = (WAIT_STATES == 0);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rd_prev_q, wr_prev_q;
  logic              proto_err_q, proto_err_d;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic              rd_rise, wr_rise;
  logic              violation;
  logic              mem_we;
  logic              rd_capture;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdat;

  assign rd_rise = rd_req & ~rd_prev_q;
  assign wr_rise = wr_req & ~wr_prev_q;

  // Next-state logic. In IDLE, the RAM address follows addr_in when the MAR is loaded on the same edge as a request.
  always_comb begin
    state_d     = state_q;
    mar_d       = mar_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    violation   = 1'b0;
    mem_we      = 1'b0;
    rd_capture  = 1'b0;
    mem_addr    = mar_q;
    mem_wdat    = wdata_q;
    case (state_q)
      IDLE: begin
        if (mar_load) begin
          mar_d    = addr_in;
          mem_addr = addr_in;
        end
        if (rd_rise && wr_rise) begin
          violation = 1'b1;
        end else if (rd_rise) begin
          if (NO_WAIT) begin
            state_d    = RD_ACK;
            rd_capture = 1'b1;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else if (wr_rise) begin
          wdata_d = wdata;
          if (NO_WAIT) begin
            state_d  = WR_ACK;
            mem_we   = 1'b1;
            mem_wdat = wdata;
          end else begin
            state_d = WR_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      RD_WAIT: begin
        violation = rd_rise | wr_rise | mar_load;
        if (cnt_q == 4'd0) begin
          state_d    = RD_ACK;
          rd_capture = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_WAIT: begin
        violation = rd_rise | wr_rise | mar_load;
        if (cnt_q == 4'd0) begin
          state_d = WR_ACK;
          mem_we  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_ACK, WR_ACK: begin
        violation = rd_rise | wr_rise | mar_load;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky error flag: clr_err clears it, but a violation on the same edge takes priority.
  always_comb begin
    proto_err_d = clr_err ? 1'b0 : proto_err_q;
    if (violation) proto_err_d = 1'b1;
  end

  // Read data is sampled only on the edge that enters RD_ACK; otherwise rdata holds its value.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_capture) rdata_d = mem[mem_addr];
  end

  // Control and datapath registers, cleared by an asynchronous reset that also aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mar_q       <= '0;
      rdata_q     <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rd_prev_q   <= 1'b0;
      wr_prev_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      rdata_q     <= rdata_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rd_prev_q   <= rd_req;
      wr_prev_q   <= wr_req;
      proto_err_q <= proto_err_d;
    end
  end

  // RAM write port. The array itself is not reset, and writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (mem_we && reset) mem[mem_addr] <= mem_wdat;
  end

  assign ack       = (state_q == RD_ACK) || (state_q == WR_ACK);
  assign rdata_oe  = (state_q == RD_ACK);
  assign busy      = (state_q != IDLE);
  assign rdata     = rdata_q;
  assign mar_out   = mar_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder, using three instances with WAIT_STATES of 1, 0 and 3.
// All instances share the same stimulus; each phase checks only the instance under test.
// Expected read data goes into a queue when a read is driven and is popped when ack appears.
module tb_data_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       mar_load;
  logic [7:0] addr_in;
  logic       rd_req;
  logic       wr_req;
  logic [7:0] wdata;
  logic       clr_err;

  logic [7:0] rdata     [3];
  logic       rdata_oe  [3];
  logic       ack       [3];
  logic       busy      [3];
  logic [7:0] mar_out   [3];
  logic       proto_err [3];

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [10];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(1)) u0 (
    .clk(clk), .reset(reset), .mar_load(mar_load), .addr_in(addr_in),
    .rd_req(rd_req), .wr_req(wr_req), .wdata(wdata), .clr_err(clr_err),
    .rdata(rdata[0]), .rdata_oe(rdata_oe[0]), .ack(ack[0]), .busy(busy[0]),
    .mar_out(mar_out[0]), .proto_err(proto_err[0]));

  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) u1 (
    .clk(clk), .reset(reset), .mar_load(mar_load), .addr_in(addr_in),
    .rd_req(rd_req), .wr_req(wr_req), .wdata(wdata), .clr_err(clr_err),
    .rdata(rdata[1]), .rdata_oe(rdata_oe[1]), .ack(ack[1]), .busy(busy[1]),
    .mar_out(mar_out[1]), .proto_err(proto_err[1]));

  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(3)) u2 (
    .clk(clk), .reset(reset), .mar_load(mar_load), .addr_in(addr_in),
    .rd_req(rd_req), .wr_req(wr_req), .wdata(wdata), .clr_err(clr_err),
    .rdata(rdata[2]), .rdata_oe(rdata_oe[2]), .ack(ack[2]), .busy(busy[2]),
    .mar_out(mar_out[2]), .proto_err(proto_err[2]));

  function automatic int ws_of(int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d): got 0x%0h, expected 0x%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One complete access: load the MAR together with a strobe rise, wait for ack (bounded), then check latency, data and the ack pulse.
  task automatic do_access(int k, bit wr, logic [7:0] a, logic [7:0] d, logic [7:0] exp);
    int n;
    logic [7:0] e;
    mar_load = 1'b1;
    addr_in  = a;
    wdata    = d;
    if (wr) wr_req = 1'b1;
    else begin
      rd_req = 1'b1;
      exp_q.push_back(exp);
    end
    tick();
    mar_load = 1'b0;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    n = 0;
    while (ack[k] !== 1'b1 && n < 20) begin
      check("busy_during_wait", k, busy[k], 1);
      tick();
      n++;
    end
    check("ack_latency", k, n, ws_of(k));
    check("busy_in_ack", k, busy[k], 1);
    check("rdata_oe", k, rdata_oe[k], !wr);
    check("mar_out", k, mar_out[k], a);
    if (!wr) begin
      e = exp_q.pop_front();
      check("rdata", k, rdata[k], e);
    end
    tick();
    check("ack_one_cycle", k, ack[k], 0);
    check("busy_back_idle", k, busy[k], 0);
  endtask

  initial begin
    int acks;
    logic [7:0] e;

    vecs[0] = '{1'b1, 8'h10, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 8'h00, 8'h01, 8'h00};
    vecs[3] = '{1'b1, 8'hFF, 8'h5A, 8'h00};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h01};
    vecs[5] = '{1'b0, 8'hFF, 8'h00, 8'h5A};
    vecs[6] = '{1'b1, 8'h7F, 8'h80, 8'h00};
    vecs[7] = '{1'b1, 8'h10, 8'hC3, 8'h00};
    vecs[8] = '{1'b0, 8'h7F, 8'h00, 8'h80};
    vecs[9] = '{1'b0, 8'h10, 8'h00, 8'hC3};

    reset    = 1'b0;
    mar_load = 1'b0;
    addr_in  = 8'h00;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    wdata    = 8'h00;
    clr_err  = 1'b0;
    idle(2);

    // Reset state of every instance.
    for (int k = 0; k < 3; k++) begin
      check("rst_ack", k, ack[k], 0);
      check("rst_rdata_oe", k, rdata_oe[k], 0);
      check("rst_busy", k, busy[k], 0);
      check("rst_proto_err", k, proto_err[k], 0);
      check("rst_rdata", k, rdata[k], 0);
      check("rst_mar", k, mar_out[k], 0);
    end
    reset = 1'b1;
    idle(2);

    // Table-driven write/read traffic on the one-wait-state instance.
    for (int i = 0; i < 10; i++) begin
      do_access(0, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp);
    end
    check("no_err_after_table", 0, proto_err[0], 0);

    // Zero wait states: 0x3C written to the top address, then read back.
    do_access(1, 1'b1, 8'hFF, 8'h3C, 8'h00);
    do_access(1, 1'b0, 8'hFF, 8'h00, 8'h3C);

    // MAR load on the same edge as a read: the read must use the new address.
    do_access(0, 1'b1, 8'h20, 8'h11, 8'h00);
    mar_load = 1'b1;
    addr_in  = 8'h05;
    tick();
    mar_load = 1'b0;
    check("mar_plain_load", 0, mar_out[0], 8'h05);
    do_access(0, 1'b0, 8'h20, 8'h00, 8'h11);

    // Read and write strobes rising together: neither is serviced, and the error flag is set.
    rd_req = 1'b1;
    wr_req = 1'b1;
    tick();
    check("both_rise_err", 0, proto_err[0], 1);
    check("both_rise_busy", 0, busy[0], 0);
    check("both_rise_ack", 0, ack[0], 0);
    rd_req = 1'b0;
    wr_req = 1'b0;
    tick();
    check("both_rise_no_ack", 0, ack[0], 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_err", 0, proto_err[0], 0);

    // MAR load during RD_WAIT is dropped; the held read strobe itself is not a violation.
    rd_req = 1'b1;
    tick();
    check("rdwait_busy", 0, busy[0], 1);
    check("rdwait_no_err", 0, proto_err[0], 0);
    mar_load = 1'b1;
    addr_in  = 8'h99;
    tick();
    mar_load = 1'b0;
    check("busy_load_ack", 0, ack[0], 1);
    check("busy_load_mar", 0, mar_out[0], 8'h20);
    check("busy_load_err", 0, proto_err[0], 1);
    check("busy_load_rdata", 0, rdata[0], 8'h11);
    rd_req = 1'b0;
    tick();

    // A violation on the same edge as clr_err leaves the flag set.
    clr_err = 1'b1;
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    tick();
    check("set_beats_clear", 0, proto_err[0], 1);
    rd_req = 1'b0;
    wr_req = 1'b0;
    tick();
    clr_err = 1'b0;
    check("clear_after", 0, proto_err[0], 0);
    idle(6);

    // Reset during WR_WAIT (three wait states): the write must never be committed.
    do_access(2, 1'b1, 8'h40, 8'h00, 8'h00);
    idle(2);
    mar_load = 1'b1;
    addr_in  = 8'h40;
    wdata    = 8'h77;
    wr_req   = 1'b1;
    tick();
    mar_load = 1'b0;
    wr_req   = 1'b0;
    tick();
    check("abort_in_wait", 2, busy[2], 1);
    reset = 1'b0;
    #1;
    check("abort_busy", 2, busy[2], 0);
    check("abort_ack", 2, ack[2], 0);
    check("abort_oe", 2, rdata_oe[2], 0);
    check("abort_err", 2, proto_err[2], 0);
    check("abort_mar", 2, mar_out[2], 0);
    check("abort_rdata", 2, rdata[2], 0);
    idle(2);
    reset = 1'b1;
    idle(2);
    do_access(2, 1'b0, 8'h40, 8'h00, 8'h00);
    idle(4);

    // Read strobe held high for ten cycles produces exactly one ack and no error.
    mar_load = 1'b1;
    addr_in  = 8'h10;
    rd_req   = 1'b1;
    exp_q.push_back(8'hC3);
    tick();
    mar_load = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (ack[0] === 1'b1) begin
        acks++;
        e = exp_q.pop_front();
        check("held_rdata", 0, rdata[0], e);
      end
      tick();
    end
    rd_req = 1'b0;
    tick();
    check("held_one_ack", 0, acks, 1);
    check("held_no_err", 0, proto_err[0], 0);
    check("sb_drained", 0, exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU data bus.
- Services the control unit's D_MAR load and D-memory read/write strobes against an internal 2**ADDR_W x DATA_W RAM.
- Inserts configurable wait states and returns a one-cycle `ack` when each access completes.
- Sits between the control unit and the data/stack memory; all addresses, including stack pointer addresses, reach it through the MAR.

Parameters:
ADDR_W, 8, MAR/address width; RAM depth is 2**ADDR_W
DATA_W, 8, data word width
WAIT_STATES, 1, idle cycles inserted between request acceptance and ack (0..15)

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets)
mar_load  in  1  load MAR from addr_in
addr_in  in  ADDR_W  address bus from control unit / SP
rd_req  in  1  read strobe; a rising edge starts a read
wr_req  in  1  write strobe; a rising edge starts a write
wdata  in  DATA_W  write data
clr_err  in  1  synchronous clear of proto_err
rdata  out  DATA_W  read data; holds the last read value
rdata_oe  out  1  bus drive enable for rdata; equals ack during reads
ack  out  1  one-cycle pulse: access completed
busy  out  1  high whenever state != IDLE
mar_out  out  ADDR_W  current MAR contents
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; mar, rdata, wait counter and wdata latch = 0.
  - rd_prev = wr_prev = 0.
  - ack, rdata_oe, busy, proto_err = 0.
  - RAM contents are not reset (zero at simulation start).
- Edge detection: rd_rise = rd_req & ~rd_prev; wr_rise = wr_req & ~wr_prev.
  - rd_prev/wr_prev register every clock.
  - A strobe held high across reset release counts as a rising edge on the first clock.
- States: IDLE, RD_WAIT, RD_ACK, WR_WAIT, WR_ACK.
- IDLE:
  - mar_load=1: mar <= addr_in.
  - Same edge as a request: the request uses the new addr_in, not the old mar.
  - rd_rise only: go to RD_WAIT, cnt <= WAIT_STATES-1; if WAIT_STATES=0, go directly to RD_ACK.
  - wr_rise only: latch wdata, then the same transitions toward WR_WAIT/WR_ACK.
  - rd_rise & wr_rise together: neither serviced, proto_err <= 1, stay IDLE.
- RD_WAIT / WR_WAIT: cnt decrements each clock; at cnt==0 advance to RD_ACK / WR_ACK.
- Read data capture: rdata <= mem[mar] on the edge entering RD_ACK.
- Write commit: mem[mar] <= latched wdata on the edge entering WR_ACK. No RAM write occurs in any other state.
- RD_ACK / WR_ACK: ack=1 for exactly one cycle, then IDLE.
  - rdata_oe=1 only in RD_ACK.
- Latency: ack is high in the cycle starting WAIT_STATES+1 clocks after the accepting edge.
  - Back-to-back requests are possible: a new rising edge may be accepted on the edge leaving *_ACK only if state is IDLE at that edge, so the minimum repeat is WAIT_STATES+2 cycles.
- While busy: rd_rise, wr_rise or mar_load are ignored (mar unchanged) and set proto_err <= 1.
  - Strobe levels held high from the accepted request are not errors.
- proto_err is sticky.
  - clr_err=1 clears it on the next edge.
  - If a violation occurs on the same edge as clr_err, the set wins.
- Address wrap: mar is ADDR_W bits; every address is valid and there is no out-of-range condition.
- Reset mid-operation aborts immediately. A write in WR_WAIT is never committed; ack is not issued.

Test Plan:
- Basic write/read, WAIT_STATES=1: mar_load addr 0x10; wr_req rise with wdata=0xA5 -> ack 2 cycles later. Then rd_req rise -> ack+rdata_oe 2 cycles later, rdata=0xA5.
- Zero wait (WAIT_STATES=0): write 0x3C to 0xFF, read back -> ack 1 cycle after each accept; rdata=0x3C; busy high for exactly 1 cycle per access.
- Same-edge load+read: mem[0x20]=0x11, mar=0x05, then mar_load(addr_in=0x20) with rd rise on one edge -> rdata=0x11 and mar_out=0x20.
- Protocol errors:
  - rd_req and wr_req rise together -> no ack, state stays IDLE, proto_err=1.
  - Clear with clr_err, then issue mar_load during RD_WAIT -> mar unchanged, proto_err=1.
- Reset abort: WAIT_STATES=3, mem[0x40]=0x00; write 0x77 to 0x40; pull reset low during WR_WAIT -> all outputs 0 immediately. A later read of 0x40 returns 0x00.
- Held strobe: rd_req held high for 10 cycles -> exactly one ack, proto_err stays 0.
